// File: rtl/fifo_sync_param_if.sv
// Producer/consumer-facing signal bundle for fifo_sync_param.
// The FIFO takes the slave view; the user of the FIFO takes the master view.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, we, re, data_in,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, we, re, data_in,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable thresholds, sticky error
// flags, synchronous flush and optional first-word-fall-through output.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready_reg;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  rd_valid_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic full;
    logic empty;
    logic flush_now;
    logic wr_acc;
    logic rd_acc;
    logic bypass;
    logic mem_we;
    logic mem_re;

    // ready_reg holds off all operations until one edge after reset release.
    always_comb begin
        full      = (count_reg == CW'(DEPTH));
        empty     = (count_reg == '0);
        flush_now = ready_reg && bus.flush;
        wr_acc    = ready_reg && !bus.flush && bus.we && !full;
        rd_acc    = ready_reg && !bus.flush && bus.re && !empty;
    end

    // In FWFT mode the output register is always the head word whenever
    // count > 0; a write lands there directly if memory would otherwise be empty.
    assign bypass = FWFT && wr_acc && (empty || ((count_reg == CW'(1)) && rd_acc));
    assign mem_we = wr_acc && !bypass;
    assign mem_re = rd_acc && (!FWFT || (count_reg > CW'(1)));

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_reg     <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            if (flush_now) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                count_reg     <= '0;
                data_out_reg  <= '0;
                rd_valid_reg  <= 1'b0;
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end else begin
                if (mem_we) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (mem_re) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_next;
                if (bypass) begin
                    data_out_reg <= bus.data_in;
                end else if (mem_re) begin
                    data_out_reg <= mem[rd_ptr_reg];
                end
                rd_valid_reg <= rd_acc;
                if (ready_reg && bus.we && full) begin
                    overflow_reg <= 1'b1;
                end
                if (ready_reg && bus.re && empty) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out     = data_out_reg;
    assign bus.rd_valid     = FWFT ? !empty : rd_valid_reg;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed checks of fifo_sync_param in standard and FWFT modes, plus small
// and large parameter sets with a scoreboard-driven random push/pop run.
module tb_fifo_sync_param;
    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    fifo_sync_param_if #(.DATA_WIDTH(8),  .DEPTH(16)) b0 ();
    fifo_sync_param_if #(.DATA_WIDTH(8),  .DEPTH(16)) b1 ();
    fifo_sync_param_if #(.DATA_WIDTH(1),  .DEPTH(4))  b2 ();
    fifo_sync_param_if #(.DATA_WIDTH(32), .DEPTH(64)) b3 ();

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u0 (
        .clk(clk), .reset(reset), .bus(b0));
    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u1 (
        .clk(clk), .reset(reset), .bus(b1));
    fifo_sync_param #(.DATA_WIDTH(1), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) u2 (
        .clk(clk), .reset(reset), .bus(b2));
    fifo_sync_param #(.DATA_WIDTH(32), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(5), .FWFT(1'b0)) u3 (
        .clk(clk), .reset(reset), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] q[$];
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    bit          w_req;
    bit          r_req;
    bit          w_ok;
    bit          r_ok;
    logic [0:0]  pat[4];

    initial begin
        reset = 1'b1;
        b0.flush = 0; b0.we = 0; b0.re = 0; b0.data_in = '0;
        b1.flush = 0; b1.we = 0; b1.re = 0; b1.data_in = '0;
        b2.flush = 0; b2.we = 0; b2.re = 0; b2.data_in = '0;
        b3.flush = 0; b3.we = 0; b3.re = 0; b3.data_in = '0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;

        // Reset values
        #2 reset = 1'b0;
        #1;
        chk("rst_count", b0.count, 0);
        chk("rst_empty", b0.empty, 1);
        chk("rst_full", b0.full, 0);
        chk("rst_ae", b0.almost_empty, 1);
        chk("rst_af", b0.almost_full, 0);
        chk("rst_ovf", b0.overflow, 0);
        chk("rst_unf", b0.underflow, 0);
        chk("rst_dout", b0.data_out, 0);
        chk("rst_rdv", b0.rd_valid, 0);
        @(negedge clk) reset = 1'b1;
        cyc();

        // Fill 16 words
        for (int i = 0; i < 16; i++) begin
            b0.we = 1; b0.data_in = 8'(i);
            cyc();
            chk($sformatf("fill_count%0d", i), b0.count, i + 1);
            chk($sformatf("fill_af%0d", i), b0.almost_full, (i + 1) >= 14);
            chk($sformatf("fill_full%0d", i), b0.full, (i + 1) == 16);
        end
        // 17th write while full
        b0.data_in = 8'hEE;
        cyc();
        chk("ovf_count", b0.count, 16);
        chk("ovf_flag", b0.overflow, 1);
        b0.we = 0;
        cyc();
        chk("ovf_sticky", b0.overflow, 1);

        // Drain 16 words
        for (int i = 0; i < 16; i++) begin
            b0.re = 1;
            cyc();
            chk($sformatf("drain_data%0d", i), b0.data_out, i);
            chk($sformatf("drain_rdv%0d", i), b0.rd_valid, 1);
            chk($sformatf("drain_count%0d", i), b0.count, 15 - i);
            chk($sformatf("drain_ae%0d", i), b0.almost_empty, (15 - i) <= 2);
        end
        b0.re = 0;
        cyc();
        chk("drain_rdv_low", b0.rd_valid, 0);
        chk("drain_empty", b0.empty, 1);
        chk("drain_hold", b0.data_out, 8'h0F);

        // Read while empty
        b0.re = 1;
        cyc();
        chk("unf_flag", b0.underflow, 1);
        chk("unf_dout", b0.data_out, 8'h0F);
        chk("unf_rdv", b0.rd_valid, 0);
        chk("unf_count", b0.count, 0);
        b0.re = 0;

        // Flush clears error flags
        b0.flush = 1;
        cyc();
        b0.flush = 0;
        chk("flush_ovf", b0.overflow, 0);
        chk("flush_unf", b0.underflow, 0);
        chk("flush_count", b0.count, 0);
        chk("flush_dout", b0.data_out, 0);

        // Preload 5, then 40 simultaneous write+read cycles across wrap
        for (int i = 0; i < 5; i++) begin
            b0.we = 1; b0.data_in = 8'(8'h10 + i);
            cyc();
        end
        chk("pre5_count", b0.count, 5);
        for (int k = 0; k < 40; k++) begin
            b0.we = 1; b0.re = 1; b0.data_in = 8'(8'h20 + k);
            cyc();
            chk($sformatf("sim_count%0d", k), b0.count, 5);
            chk($sformatf("sim_data%0d", k), b0.data_out, (k < 5) ? (8'h10 + k) : (8'h20 + k - 5));
        end
        b0.re = 0;
        // Top up to full, then simultaneous write+read at full
        for (int i = 0; i < 11; i++) begin
            b0.we = 1; b0.data_in = 8'(8'h50 + i);
            cyc();
        end
        chk("topup_full", b0.full, 1);
        b0.we = 1; b0.re = 1; b0.data_in = 8'hFF;
        cyc();
        chk("fullsim_data", b0.data_out, 8'h43);
        chk("fullsim_count", b0.count, 15);
        chk("fullsim_ovf", b0.overflow, 1);
        b0.we = 0; b0.re = 0;
        b0.flush = 1;
        cyc();
        b0.flush = 0;

        // Reset mid-stream at count 9
        for (int i = 0; i < 9; i++) begin
            b0.we = 1; b0.data_in = 8'(8'h30 + i);
            cyc();
        end
        b0.we = 1; b0.re = 1; b0.data_in = 8'h39;
        cyc();
        chk("mid_count", b0.count, 9);
        chk("mid_data", b0.data_out, 8'h30);
        b0.we = 0; b0.re = 0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_count", b0.count, 0);
        chk("mid_rst_dout", b0.data_out, 0);
        chk("mid_rst_rdv", b0.rd_valid, 0);
        chk("mid_rst_empty", b0.empty, 1);
        @(negedge clk);
        reset = 1'b1;
        b0.we = 1; b0.data_in = 8'h77;
        cyc();
        chk("rel_edge1_count", b0.count, 0);
        cyc();
        chk("rel_edge2_count", b0.count, 1);
        b0.we = 0; b0.re = 1;
        cyc();
        chk("rel_data", b0.data_out, 8'h77);
        chk("rel_rdv", b0.rd_valid, 1);
        b0.re = 0;

        // FWFT mode
        b1.we = 1; b1.data_in = 8'hA5;
        cyc();
        chk("fw_a5_empty", b1.empty, 0);
        chk("fw_a5_data", b1.data_out, 8'hA5);
        chk("fw_a5_rdv", b1.rd_valid, 1);
        chk("fw_a5_count", b1.count, 1);
        b1.data_in = 8'h3C;
        cyc();
        chk("fw_3c_count", b1.count, 2);
        chk("fw_3c_head", b1.data_out, 8'hA5);
        b1.we = 0; b1.re = 1;
        cyc();
        chk("fw_pop1_data", b1.data_out, 8'h3C);
        chk("fw_pop1_empty", b1.empty, 0);
        cyc();
        chk("fw_pop2_empty", b1.empty, 1);
        chk("fw_pop2_count", b1.count, 0);
        cyc();
        chk("fw_unf", b1.underflow, 1);
        b1.re = 0;
        for (int i = 0; i < 3; i++) begin
            b1.we = 1; b1.data_in = 8'(8'h11 * (i + 1));
            cyc();
            chk($sformatf("fw_stream_head%0d", i), b1.data_out, 8'h11);
        end
        b1.we = 0; b1.re = 1;
        cyc();
        chk("fw_stream_22", b1.data_out, 8'h22);
        cyc();
        chk("fw_stream_33", b1.data_out, 8'h33);
        cyc();
        chk("fw_stream_empty", b1.empty, 1);
        b1.re = 0; b1.we = 1; b1.data_in = 8'h44;
        cyc();
        chk("fw_44", b1.data_out, 8'h44);
        b1.re = 1; b1.data_in = 8'h55;
        cyc();
        chk("fw_bypass_data", b1.data_out, 8'h55);
        chk("fw_bypass_count", b1.count, 1);
        b1.we = 0;
        cyc();
        chk("fw_final_empty", b1.empty, 1);
        b1.re = 0;

        // DEPTH=4, DATA_WIDTH=1, AF=3, AE=1
        for (int i = 0; i < 4; i++) begin
            b2.we = 1; b2.data_in = pat[i];
            cyc();
            chk($sformatf("d4_count%0d", i), b2.count, i + 1);
            chk($sformatf("d4_ae%0d", i), b2.almost_empty, (i + 1) <= 1);
            chk($sformatf("d4_af%0d", i), b2.almost_full, (i + 1) >= 3);
            chk($sformatf("d4_full%0d", i), b2.full, (i + 1) == 4);
        end
        b2.we = 0;
        for (int i = 0; i < 4; i++) begin
            b2.re = 1;
            cyc();
            chk($sformatf("d4_data%0d", i), b2.data_out, pat[i]);
            chk($sformatf("d4_ae_rd%0d", i), b2.almost_empty, (3 - i) <= 1);
            chk($sformatf("d4_af_rd%0d", i), b2.almost_full, (3 - i) >= 3);
        end
        b2.re = 0;
        cyc();
        chk("d4_empty", b2.empty, 1);

        // DEPTH=64, DATA_WIDTH=32 random run against a queue
        for (int n = 0; n < 2000; n++) begin
            if ((n % 1000) < 500) begin
                w_req = ($urandom_range(3, 0) != 0);
                r_req = ($urandom_range(3, 0) == 0);
            end else begin
                w_req = ($urandom_range(3, 0) == 0);
                r_req = ($urandom_range(3, 0) != 0);
            end
            wr_word = $urandom;
            w_ok = w_req && (q.size() < 64);
            r_ok = r_req && (q.size() != 0);
            b3.we = w_req; b3.re = r_req; b3.data_in = wr_word;
            cyc();
            if (r_ok) begin
                rd_word = q.pop_front();
                chk($sformatf("rnd_data%0d", n), b3.data_out, rd_word);
            end
            if (w_ok) q.push_back(wr_word);
            chk($sformatf("rnd_rdv%0d", n), b3.rd_valid, r_ok);
            chk($sformatf("rnd_count%0d", n), b3.count, q.size());
            chk($sformatf("rnd_af%0d", n), b3.almost_full, q.size() >= 60);
            chk($sformatf("rnd_ae%0d", n), b3.almost_empty, q.size() <= 5);
            chk($sformatf("rnd_full%0d", n), b3.full, q.size() == 64);
        end
        b3.we = 0; b3.re = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
